// File: rtl/dijkstra_sched.sv
// Single-source shortest-path engine: linear-scan node selection, streamed edge
// relaxation from an external 1-cycle-latency edge memory, and a result stream.
module dijkstra_sched #(
  parameter int DW   = 16,
  parameter int NMAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    n,
  input  logic [7:0]    e,
  input  logic [3:0]    src,
  output logic          edge_rd,
  output logic [7:0]    edge_addr,
  input  logic [11:0]   edge_data,
  output logic          busy,
  output logic          dist_valid,
  input  logic          dist_ready,
  output logic [3:0]    dist_node,
  output logic [DW-1:0] dist_val,
  output logic          done
);

  localparam logic [DW-1:0] INF = '1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_SELECT = 3'd2;
  localparam logic [2:0] S_RELAX  = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_OUTPUT = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [4:0]    n_q, n_d;
  logic [7:0]    e_q, e_d;
  logic [3:0]    src_q, src_d;
  logic [3:0]    scan_q, scan_d;
  logic [3:0]    best_q, best_d;
  logic [DW-1:0] best_dist_q, best_dist_d;
  logic          found_q, found_d;
  logic [3:0]    u_q, u_d;
  logic [7:0]    addr_q, addr_d;
  logic [3:0]    out_q, out_d;
  logic          done_q, done_d;
  logic          rd_pend_q;
  logic          visit_en;

  logic [DW-1:0] dist_q [NMAX];
  logic [NMAX-1:0] visited_q;

  logic [3:0]  e_parent, e_child, e_w;
  logic [DW:0] relax_sum;
  logic        relax_en;
  logic        cand_ok;
  logic        scan_last, addr_last, out_last, xfer;

  assign e_parent = edge_data[3:0];
  assign e_child  = edge_data[7:4];
  assign e_w      = edge_data[11:8];

  // The sum is one bit wider so an overflow can never compare below a real distance.
  assign relax_sum = {1'b0, dist_q[u_q]} + {{(DW-3){1'b0}}, e_w};
  assign relax_en  = rd_pend_q && (e_parent == u_q) && ({1'b0, e_child} < n_q) &&
                     !visited_q[e_child] && (relax_sum < {1'b0, dist_q[e_child]});

  // Strict compare keeps the earlier (lower-index) node on equal distances.
  assign cand_ok   = !visited_q[scan_q] && (dist_q[scan_q] != INF) &&
                     (!found_q || (dist_q[scan_q] < best_dist_q));

  assign scan_last = ({1'b0, scan_q} == (n_q - 5'd1));
  assign addr_last = (addr_q == (e_q - 8'd1));
  assign out_last  = ({1'b0, out_q} == (n_q - 5'd1));
  assign xfer      = dist_valid && dist_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d     = state_q;
    n_d         = n_q;
    e_d         = e_q;
    src_d       = src_q;
    scan_d      = scan_q;
    best_d      = best_q;
    best_dist_d = best_dist_q;
    found_d     = found_q;
    u_d         = u_q;
    addr_d      = addr_q;
    out_d       = out_q;
    done_d      = 1'b0;
    visit_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = (n == 4'd0) ? 5'd16 : {1'b0, n};
          e_d     = e;
          src_d   = src;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        scan_d  = 4'd0;
        found_d = 1'b0;
        state_d = S_SELECT;
      end
      S_SELECT: begin
        found_d = found_q | cand_ok;
        if (cand_ok) begin
          best_d      = scan_q;
          best_dist_d = dist_q[scan_q];
        end
        scan_d = scan_q + 4'd1;
        if (scan_last) begin
          scan_d  = 4'd0;
          found_d = 1'b0;
          if (found_q || cand_ok) begin
            u_d      = cand_ok ? scan_q : best_q;
            visit_en = 1'b1;
            addr_d   = 8'd0;
            state_d  = (e_q == 8'd0) ? S_DRAIN : S_RELAX;
          end else begin
            out_d   = 4'd0;
            state_d = S_OUTPUT;
          end
        end
      end
      S_RELAX: begin
        addr_d = addr_q + 8'd1;
        if (addr_last) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_SELECT;
      S_OUTPUT: begin
        if (xfer) begin
          if (out_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            out_d = out_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q     <= S_IDLE;
      n_q         <= 5'd0;
      e_q         <= 8'd0;
      src_q       <= 4'd0;
      scan_q      <= 4'd0;
      best_q      <= 4'd0;
      best_dist_q <= '0;
      found_q     <= 1'b0;
      u_q         <= 4'd0;
      addr_q      <= 8'd0;
      out_q       <= 4'd0;
      done_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      visited_q   <= '0;
      // NOTE: the distance table is a small flop array with an observable reset
      // value, so it is reset here rather than left uninitialised like a RAM.
      for (int i = 0; i < NMAX; i++) dist_q[i] <= INF;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      e_q         <= e_d;
      src_q       <= src_d;
      scan_q      <= scan_d;
      best_q      <= best_d;
      best_dist_q <= best_dist_d;
      found_q     <= found_d;
      u_q         <= u_d;
      addr_q      <= addr_d;
      out_q       <= out_d;
      done_q      <= done_d;
      rd_pend_q   <= edge_rd;
      if (state_q == S_INIT) begin
        for (int i = 0; i < NMAX; i++) dist_q[i] <= INF;
        dist_q[src_q] <= '0;
        visited_q     <= '0;
      end
      if (visit_en) visited_q[u_d] <= 1'b1;
      if (relax_en) dist_q[e_child] <= relax_sum[DW-1:0];
    end
  end

  assign edge_rd    = (state_q == S_RELAX);
  assign edge_addr  = edge_rd ? addr_q : 8'd0;
  assign busy       = (state_q != S_IDLE);
  assign dist_valid = (state_q == S_OUTPUT);
  assign dist_node  = dist_valid ? out_q : 4'd0;
  assign dist_val   = dist_valid ? dist_q[out_q] : '0;
  assign done       = done_q;

endmodule

// File: tb/tb_dijkstra_sched.sv
// Bench for dijkstra_sched: directed graphs plus random graphs, with results
// compared against a Bellman-Ford shortest-path model and an edge-memory model.
module tb_dijkstra_sched;

  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic [3:0]    n;
  logic [7:0]    e;
  logic [3:0]    src;
  logic          edge_rd;
  logic [7:0]    edge_addr;
  logic [11:0]   edge_data;
  logic          busy;
  logic          dist_valid;
  logic          dist_ready;
  logic [3:0]    dist_node;
  logic [DW-1:0] dist_val;
  logic          done;

  int total = 0;
  int bad   = 0;

  logic [11:0]   mem [256];
  logic [DW-1:0] exp_dist [16];
  int            exp_passes;

  int   rd_cnt = 0;
  int   done_cnt = 0;
  int   addr_err = 0;
  logic prev_rd = 1'b0;
  logic [7:0] prev_addr = 8'd0;

  dijkstra_sched #(.DW(DW), .NMAX(16)) dut (
    .clk(clk), .reset(reset), .start(start), .n(n), .e(e), .src(src),
    .edge_rd(edge_rd), .edge_addr(edge_addr), .edge_data(edge_data),
    .busy(busy), .dist_valid(dist_valid), .dist_ready(dist_ready),
    .dist_node(dist_node), .dist_val(dist_val), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge memory: data returns one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (edge_rd === 1'b1) edge_data <= mem[edge_addr];
    else                  edge_data <= 12'($urandom);
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (edge_rd === 1'b1) begin
      rd_cnt++;
      if (edge_addr !== (prev_rd ? prev_addr + 8'd1 : 8'd0)) addr_err++;
    end else if (edge_addr !== 8'd0) begin
      addr_err++;
    end
    prev_rd   = edge_rd;
    prev_addr = edge_addr;
  end

  task automatic set_edge(input int idx, input int p, input int c, input int w);
    mem[idx] = {w[3:0], c[3:0], p[3:0]};
  endtask

  // Reference: Bellman-Ford over nodes 0..neff-1; unreachable nodes are INF.
  task automatic model(input int neff, input int ee, input int s);
    int d [16];
    int p, c, w;
    for (int i = 0; i < 16; i++) d[i] = -1;
    if (s < neff) d[s] = 0;
    for (int it = 0; it < neff; it++)
      for (int k = 0; k < ee; k++) begin
        p = int'(mem[k][3:0]);
        c = int'(mem[k][7:4]);
        w = int'(mem[k][11:8]);
        if (p < neff && c < neff && d[p] >= 0 && (d[c] < 0 || d[p] + w < d[c]))
          d[c] = d[p] + w;
      end
    exp_passes = 0;
    for (int i = 0; i < 16; i++) begin
      exp_dist[i] = (d[i] < 0) ? 16'hFFFF : DW'(d[i]);
      if (i < neff && d[i] >= 0) exp_passes++;
    end
  endtask

  // mode: 0 = ready always high, 1 = ready toggles, 2 = ready random.
  task automatic run_case(input string name, input logic [3:0] nn, input int ee,
                          input logic [3:0] s, input int mode, input bit inject);
    int neff, got, cycles, rd0, dn0, ae0;
    bit stalled, injected, finished;
    logic [3:0]    pn;
    logic [DW-1:0] pv;
    neff = (nn == 4'd0) ? 16 : int'(nn);
    model(neff, ee, s);
    rd0 = rd_cnt; dn0 = done_cnt; ae0 = addr_err;
    got = 0; cycles = 0; stalled = 0; injected = 0; finished = 0;
    pn = 4'd0; pv = '0;
    dist_ready = 1'b1;
    @(negedge clk);
    n = nn; e = ee[7:0]; src = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL %s busy_after_start got=%b want=1", name, busy);
    end
    while (!finished && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (inject && !injected && edge_rd === 1'b1) begin
        start = 1'b1; n = ~nn; e = 8'd1; src = s + 4'd1; injected = 1;
      end
      case (mode)
        0:       dist_ready = 1'b1;
        1:       dist_ready = ~dist_ready;
        default: dist_ready = 1'($urandom);
      endcase
      if (stalled) begin
        total++;
        if (dist_valid !== 1'b1 || dist_node !== pn || dist_val !== pv) begin
          bad++;
          $display("FAIL %s stall_hold got=%b/%0d/%h want=1/%0d/%h",
                   name, dist_valid, dist_node, dist_val, pn, pv);
        end
      end
      stalled = 0;
      if (dist_valid === 1'b1) begin
        if (dist_ready) begin
          total++;
          if (dist_node !== 4'(got)) begin
            bad++; $display("FAIL %s node_order got=%0d want=%0d", name, dist_node, got);
          end
          if (got < 16) begin
            total++;
            if (dist_val !== exp_dist[got]) begin
              bad++;
              $display("FAIL %s dist[%0d] got=%h want=%h", name, got, dist_val, exp_dist[got]);
            end
          end
          got++;
        end else begin
          stalled = 1; pn = dist_node; pv = dist_val;
        end
      end
      if (done === 1'b1) finished = 1;
    end
    start = 1'b0;
    total++;
    if (!finished) begin
      bad++; $display("FAIL %s timeout got=no_done want=done", name);
    end
    repeat (3) @(negedge clk);
    total++;
    if (got !== neff) begin
      bad++; $display("FAIL %s transfers got=%0d want=%0d", name, got, neff);
    end
    total++;
    if (done_cnt - dn0 !== 1) begin
      bad++; $display("FAIL %s done_pulses got=%0d want=1", name, done_cnt - dn0);
    end
    total++;
    if (rd_cnt - rd0 !== exp_passes * ee) begin
      bad++; $display("FAIL %s edge_reads got=%0d want=%0d", name, rd_cnt - rd0, exp_passes * ee);
    end
    total++;
    if (addr_err - ae0 !== 0) begin
      bad++; $display("FAIL %s edge_addr_seq got=%0d_errors want=0", name, addr_err - ae0);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s busy_after_done got=%b want=0", name, busy);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || edge_rd !== 1'b0 || edge_addr !== 8'd0 ||
        dist_valid !== 1'b0 || dist_node !== 4'd0 || dist_val !== '0) begin
      bad++;
      $display("FAIL %s outputs got=b%b d%b r%b a%0d v%b n%0d x%h want=all_zero",
               name, busy, done, edge_rd, edge_addr, dist_valid, dist_node, dist_val);
    end
  endtask

  task automatic load_example();
    set_edge(0, 0, 1, 5);
    set_edge(1, 0, 2, 2);
    set_edge(2, 2, 1, 1);
    set_edge(3, 1, 3, 3);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_release");
  endtask

  task automatic test_example();
    load_example();
    run_case("example", 4'd4, 4, 4'd0, 0, 1'b0);
    total++;
    if (exp_dist[1] !== 16'd3 || exp_dist[3] !== 16'd6) begin
      bad++; $display("FAIL example_model got=%0d/%0d want=3/6", exp_dist[1], exp_dist[3]);
    end
  endtask

  task automatic test_no_edges();
    run_case("no_edges", 4'd3, 0, 4'd1, 0, 1'b0);
  endtask

  task automatic test_chain16();
    for (int i = 0; i < 15; i++) set_edge(i, i, i + 1, 15);
    run_case("chain16", 4'd0, 15, 4'd0, 0, 1'b0);
  endtask

  task automatic test_stall();
    load_example();
    run_case("stall_toggle", 4'd4, 4, 4'd0, 1, 1'b0);
  endtask

  task automatic test_start_ignored();
    load_example();
    run_case("start_in_relax", 4'd4, 4, 4'd0, 0, 1'b1);
  endtask

  task automatic test_reset_midrun();
    int cyc, dn0;
    load_example();
    @(negedge clk);
    n = 4'd4; e = 8'd4; src = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (edge_rd !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (edge_rd !== 1'b1) begin
      bad++; $display("FAIL midrun_reach_relax got=%b want=1", edge_rd);
    end
    dn0 = done_cnt;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    reset = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (done_cnt !== dn0 || busy !== 1'b0) begin
      bad++; $display("FAIL midrun_no_done got=%0d/%b want=0/0", done_cnt - dn0, busy);
    end
    run_case("after_reset", 4'd4, 4, 4'd0, 0, 1'b0);
  endtask

  task automatic test_src_out_of_range();
    set_edge(0, 0, 1, 1);
    run_case("src_oor", 4'd2, 1, 4'd5, 0, 1'b0);
  endtask

  task automatic test_random();
    int neff, ee;
    for (int t = 0; t < 6; t++) begin
      neff = int'($urandom_range(1, 16));
      ee   = int'($urandom_range(0, 40));
      for (int k = 0; k < ee; k++)
        set_edge(k, int'($urandom_range(0, neff)), int'($urandom_range(0, neff)),
                 int'($urandom_range(0, 15)));
      run_case($sformatf("random%0d", t), 4'(neff), ee,
               4'($urandom_range(0, neff - 1)), 2, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; n = 4'd0; e = 8'd0; src = 4'd0; dist_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 12'd0;
    test_reset();
    test_example();
    test_no_edges();
    test_chain16();
    test_stall();
    test_start_ignored();
    test_reset_midrun();
    test_src_out_of_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dijkstra_sched.md
DIJKSTRA_SCHED -- requirements
Module: dijkstra_sched

Interface
REQ-001 Parameter DW, default 16, distance width in bits; all-ones (16'hFFFF) = INF (unreachable).
REQ-002 Parameter NMAX, default 16, maximum node count; node index is 4 bits.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-006 n  in  4  node count; 0 encodes 16; sampled on accepted start.
REQ-007 e  in  8  edge count, 0..255; sampled on accepted start.
REQ-008 src  in  4  source node; sampled on accepted start.
REQ-009 edge_rd  out  1  edge memory read strobe.
REQ-010 edge_addr  out  8  edge memory address, valid with edge_rd.
REQ-011 edge_data  in  12  edge word, valid exactly 1 cycle after edge_rd: [3:0] parent, [7:4] child, [11:8] weight.
REQ-012 busy  out  1  high from the cycle after start is accepted until done.
REQ-013 dist_valid / dist_ready  out / in  1 / 1  result stream handshake.
REQ-014 dist_node / dist_val  out / out  4 / DW  result node index and its distance.
REQ-015 done  out  1  one-cycle pulse after last result transfer.

Function
REQ-016 FSM states: IDLE, INIT, SELECT, RELAX, DRAIN, OUTPUT.
REQ-017 IDLE: start=1 latches n, e, src; next state INIT; start in any other state is ignored.
REQ-018 INIT (1 cycle): dist[all]=INF, dist[src]=0, visited[all]=0; next SELECT.
REQ-019 SELECT: scan nodes 0..n-1, one per cycle (n cycles); candidate = unvisited node with dist != INF and smallest dist; ties -> lowest index.
REQ-020 SELECT end, no candidate: next OUTPUT; candidate u found: visited[u]=1, next RELAX (next DRAIN when e=0).
REQ-021 RELAX: edge_rd=1 with edge_addr 0..e-1 on consecutive cycles, one read per cycle, no gaps; after address e-1 next DRAIN.
REQ-022 Each returned edge word is processed in the cycle it arrives: if parent==u, child<n and child not visited and dist[u]+weight (DW+1-bit sum) < dist[child], then dist[child] <= sum.
REQ-023 Edge processing is in address order; a relaxation updates dist in time for the following edge word to the same child.
REQ-024 Edges with parent>=n or child>=n are ignored; self-loops leave dist unchanged.
REQ-025 DRAIN (1 cycle): process the final edge word; next SELECT.
REQ-026 Each SELECT+RELAX pass visits exactly one node; at most n passes per run.
REQ-027 OUTPUT: present nodes 0..n-1 in ascending order; dist_valid=1; dist_node/dist_val held stable until dist_valid&dist_ready; advance one node per transfer.
REQ-028 After node n-1 transfers: done=1 for one cycle, busy=0, state IDLE.
REQ-029 src>=n: no candidate is ever found; all n results are INF.
REQ-030 edge_rd=0 in every state except RELAX; edge_addr=0 when edge_rd=0.

Reset
REQ-031 reset=0 at a clock edge: state=IDLE, busy=0, done=0, edge_rd=0, edge_addr=0, dist_valid=0, dist_node=0, dist_val=0, visited=0, dist[all]=INF.
REQ-032 Reset mid-run (any state) aborts the run with no done pulse; the next start after reset release runs normally.

Verification
REQ-033 n=4, src=0, e=4 edges {0->1 w5, 0->2 w2, 2->1 w1, 1->3 w3}, dist_ready=1 -> results 0:0, 1:3, 2:2, 3:6; one done pulse.
REQ-034 n=3, src=1, e=0 -> no edge_rd issued; results 0:FFFF, 1:0, 2:FFFF.
REQ-035 n=0 (16 nodes), src=0, chain i->i+1 w15 for i=0..14 -> node k result 15*k, node 15 = 225; edge_rd issued 15 times per pass, 16 passes.
REQ-036 n=4, src=0, dist_ready toggling 1/0 each cycle -> each result held stable while stalled; exactly 4 transfers, done after 4th.
REQ-037 start asserted during RELAX -> ignored, run result unchanged; reset=0 during RELAX -> all outputs at reset values next cycle, no done.
REQ-038 n=2, src=5, edges {0->1 w1} -> results 0:FFFF, 1:FFFF.
